// File: rtl/spi_packet_rx.sv
// SPI (Mode 0) packet receiver. The SPI pins are synchronized into the clk
// domain. Bytes are assembled MSB first into a staging buffer. When the frame
// ends, it is validated on header, length and XOR checksum. A good frame
// updates the payload outputs; a bad or timed-out frame only bumps the error
// counter and sticky error bits.
//
// Output handshake: pkt_valid and pkt_err are single-cycle strobes with no
// ready. They are never high together. ch_data and flags change only in the
// cycle in which pkt_valid is high, and hold their values at all other times.
`timescale 1ns/1ps
module spi_packet_rx #(
  parameter int          NUM_CH      = 6,
  parameter logic [7:0]  HEADER      = 8'hAA,
  parameter int          CHK_EN      = 1,
  parameter logic [15:0] TIMEOUT_CYC = 16'd4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs_n,
  input  logic                  sck,
  input  logic                  sdi,
  input  logic                  err_clr,
  output logic [NUM_CH*16-1:0]  ch_data,
  output logic [7:0]            flags,
  output logic                  pkt_valid,
  output logic                  pkt_err,
  output logic [3:0]            err_sticky,
  output logic                  initialized,
  output logic [15:0]           ok_cnt,
  output logic [15:0]           err_cnt,
  output logic [1:0]            state_dbg
);

  localparam int PKT_BYTES = 2 + 2*NUM_CH + CHK_EN;
  localparam int BW        = $clog2(PKT_BYTES + 1);
  localparam int FLAGS_IDX = 1 + 2*NUM_CH;
  localparam logic [BW-1:0] PB_N = BW'(PKT_BYTES);
  localparam logic [BW-1:0] PB_X = BW'(PKT_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t          state;

  // [0] first sync stage, [1] second sync stage, [2] edge-detect history
  logic [2:0]      cs_sync;
  logic [2:0]      sck_sync;
  logic [2:0]      sdi_sync;
  logic [1:0]      sync_vld;
  logic            cs_armed;

  logic [2:0]      bit_cnt;
  logic [BW-1:0]   byte_cnt;
  logic            overlen;
  logic [6:0]      shreg;
  logic [7:0]      xor_acc;
  logic [15:0]     to_cnt;
  logic [7:0]      stage [PKT_BYTES];

  logic            cs_fall;
  logic            cs_rise;
  logic            cs_low;
  logic            sck_rise;
  logic            sdi_bit;
  logic [7:0]      new_byte;
  logic            len_bad;
  logic            hdr_bad;
  logic            chk_bad;
  logic            frame_empty;
  logic            accept;

  // A falling edge is honoured only after cs_n has been seen high with real
  // pin data. This keeps the synchronizer's reset level from faking a frame
  // start when reset releases while CS is already low.
  assign cs_fall  = cs_armed & ~cs_sync[1] & cs_sync[2];
  assign cs_rise  = cs_sync[1] & ~cs_sync[2];
  assign cs_low   = ~cs_sync[1];
  assign sck_rise = sck_sync[1] & ~sck_sync[2];
  assign sdi_bit  = sdi_sync[2];
  assign new_byte = {shreg, sdi_bit};

  assign len_bad     = (byte_cnt != PB_N) || (bit_cnt != 3'd0) || overlen;
  assign hdr_bad     = (byte_cnt != '0) && (stage[0] != HEADER);
  assign chk_bad     = (CHK_EN != 0) && (byte_cnt == PB_N) &&
                       (xor_acc != stage[PKT_BYTES-1]);
  assign frame_empty = (byte_cnt == '0) && (bit_cnt == 3'd0) && !overlen;
  assign accept      = !(len_bad || hdr_bad || chk_bad);

  assign state_dbg = state;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Pin synchronizers, edge history and the CS arming qualifier
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_sync  <= 3'b111;
      sck_sync <= 3'b000;
      sdi_sync <= 3'b000;
      sync_vld <= 2'b00;
      cs_armed <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[1:0], cs_n};
      sck_sync <= {sck_sync[1:0], sck};
      sdi_sync <= {sdi_sync[1:0], sdi};
      sync_vld <= {sync_vld[0], 1'b1};
      cs_armed <= cs_armed | (sync_vld[1] & cs_sync[1]);
    end
  end

  // Frame FSM: byte assembly, staging, validation and the status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      byte_cnt    <= '0;
      overlen     <= 1'b0;
      shreg       <= 7'd0;
      xor_acc     <= 8'd0;
      to_cnt      <= 16'd0;
      for (int i = 0; i < PKT_BYTES; i++) stage[i] <= 8'd0;
      ch_data     <= '0;
      flags       <= 8'd0;
      pkt_valid   <= 1'b0;
      pkt_err     <= 1'b0;
      err_sticky  <= 4'd0;
      initialized <= 1'b0;
      ok_cnt      <= 16'd0;
      err_cnt     <= 16'd0;
    end else begin
      pkt_valid <= 1'b0;
      pkt_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state    <= RECV;
            bit_cnt  <= 3'd0;
            byte_cnt <= '0;
            overlen  <= 1'b0;
            xor_acc  <= 8'd0;
            to_cnt   <= 16'd0;
          end
        end
        RECV: begin
          if (cs_rise) begin
            state <= CHECK;
          end else if (sck_rise && cs_low) begin
            to_cnt  <= 16'd0;
            bit_cnt <= bit_cnt + 3'd1;
            shreg   <= new_byte[6:0];
            if (bit_cnt == 3'd7) begin
              if (byte_cnt < PB_N) begin
                stage[byte_cnt] <= new_byte;
                byte_cnt        <= byte_cnt + 1'b1;
                if (byte_cnt < PB_X) xor_acc <= xor_acc ^ new_byte;
              end else begin
                overlen <= 1'b1;
              end
            end
          end else if (to_cnt == TIMEOUT_CYC - 16'd1) begin
            state         <= DRAIN;
            pkt_err       <= 1'b1;
            err_sticky[3] <= 1'b1;
            err_cnt       <= sat_inc(err_cnt);
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        CHECK: begin
          if (!frame_empty) begin
            if (accept) begin
              for (int k = 0; k < NUM_CH; k++)
                ch_data[16*k +: 16] <= {stage[1+2*k], stage[2+2*k]};
              flags       <= stage[FLAGS_IDX];
              pkt_valid   <= 1'b1;
              ok_cnt      <= sat_inc(ok_cnt);
              initialized <= 1'b1;
            end else begin
              pkt_err    <= 1'b1;
              err_cnt    <= sat_inc(err_cnt);
              err_sticky <= err_sticky | {1'b0, chk_bad, len_bad, hdr_bad};
            end
          end
          // A new frame may already be starting; keep its first SCK edge
          if (cs_fall) begin
            state    <= RECV;
            bit_cnt  <= 3'd0;
            byte_cnt <= '0;
            overlen  <= 1'b0;
            xor_acc  <= 8'd0;
            to_cnt   <= 16'd0;
          end else begin
            state <= IDLE;
          end
        end
        DRAIN: begin
          if (cs_sync[1]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Clearing has priority over any error recorded in the same cycle
      if (err_clr) begin
        err_cnt    <= 16'd0;
        err_sticky <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_spi_packet_rx.sv
// Bench for spi_packet_rx (NUM_CH=1, CHK_EN=1, TIMEOUT_CYC=64, PKT_BYTES=5).
// The frame outcome is computed from the transmitted bit list. Each outcome is
// queued for the cycle in which the pulse must appear. A per-cycle compare
// process then checks every output against the model.
`timescale 1ns/1ps
module tb_spi_packet_rx;

  localparam int          NUM_CH = 1;
  localparam int          PB     = 5;
  localparam logic [15:0] TO     = 16'd64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs_n = 1'b1;
  logic        sck = 1'b0;
  logic        sdi = 1'b0;
  logic        err_clr = 1'b0;
  logic [15:0] ch_data;
  logic [7:0]  flags;
  logic        pkt_valid;
  logic        pkt_err;
  logic [3:0]  err_sticky;
  logic        initialized;
  logic [15:0] ok_cnt;
  logic [15:0] err_cnt;
  logic [1:0]  state_dbg;

  spi_packet_rx #(
    .NUM_CH(NUM_CH), .HEADER(8'hAA), .CHK_EN(1), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sck(sck), .sdi(sdi),
    .err_clr(err_clr), .ch_data(ch_data), .flags(flags),
    .pkt_valid(pkt_valid), .pkt_err(pkt_err), .err_sticky(err_sticky),
    .initialized(initialized), .ok_cnt(ok_cnt), .err_cnt(err_cnt),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  typedef struct {
    int          cyc;
    bit          tmo;
    bit          acc;
    logic [3:0]  bits;
    logic [15:0] ch;
    logic [7:0]  fl;
  } ev_t;

  ev_t         ev_q[$];
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  logic [15:0] m_ch = '0;
  logic [7:0]  m_fl = '0;
  logic [3:0]  m_sticky = '0;
  logic [15:0] m_ok = '0;
  logic [15:0] m_err = '0;
  logic        m_init = 1'b0;
  logic        cmp_rst;
  logic        cmp_clr;
  logic        ev_v;
  logic        ev_e;
  int          last_valid_cyc = -1;
  int          last_err_cyc = -1;

  logic [7:0]  tx_bytes[$];
  bit          tx_bits[$];
  int          raise_cyc;
  int          last_rise;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // ---------------- compare process (every cycle) ----------------
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      cmp_rst = rst_n;
      cmp_clr = err_clr;
      #1;
      ev_v = 1'b0;
      ev_e = 1'b0;
      if (!cmp_rst) begin
        m_ch = '0; m_fl = '0; m_sticky = '0; m_ok = '0; m_err = '0; m_init = 1'b0;
        ev_q.delete();
      end else begin
        if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
          ev_t e;
          e = ev_q.pop_front();
          if (e.tmo) begin
            ev_e = 1'b1; m_sticky[3] = 1'b1; m_err = sat(m_err);
          end else if (e.acc) begin
            ev_v = 1'b1; m_ch = e.ch; m_fl = e.fl; m_ok = sat(m_ok); m_init = 1'b1;
          end else begin
            ev_e = 1'b1; m_sticky = m_sticky | e.bits; m_err = sat(m_err);
          end
        end
        if (cmp_clr) begin
          m_err = '0; m_sticky = '0;
        end
      end
      if (pkt_valid) last_valid_cyc = cyc;
      if (pkt_err)   last_err_cyc = cyc;
      chk("pkt_valid", pkt_valid, ev_v);
      chk("pkt_err", pkt_err, ev_e);
      chk("ch_data", ch_data, m_ch);
      chk("flags", flags, m_fl);
      chk("err_sticky", err_sticky, m_sticky);
      chk("ok_cnt", ok_cnt, m_ok);
      chk("err_cnt", err_cnt, m_err);
      chk("initialized", initialized, m_init);
    end
  end

  // ---------------- model: frame outcome from the bit list ----------------
  task automatic push_outcome();
    int nbits, nbytes;
    logic [7:0] b[$];
    logic [7:0] x;
    ev_t e;
    nbits = tx_bits.size();
    if (nbits == 0) return;
    nbytes = nbits / 8;
    for (int i = 0; i < nbytes; i++) begin
      logic [7:0] v;
      v = '0;
      for (int j = 0; j < 8; j++) v = {v[6:0], tx_bits[8*i+j]};
      b.push_back(v);
    end
    e.cyc = raise_cyc + 4;
    e.tmo = 1'b0;
    e.bits = '0;
    e.bits[1] = (nbits != 8*PB);
    e.bits[0] = (nbytes >= 1) && (b[0] != 8'hAA);
    if (nbytes >= PB) begin
      x = '0;
      for (int i = 0; i < PB-1; i++) x ^= b[i];
      e.bits[2] = (x != b[PB-1]);
    end
    e.acc = (e.bits == 4'd0);
    e.ch = e.acc ? {b[1], b[2]} : 16'h0;
    e.fl = e.acc ? b[3] : 8'h0;
    ev_q.push_back(e);
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic build_bits(input int extra);
    tx_bits.delete();
    foreach (tx_bytes[i])
      for (int j = 7; j >= 0; j--) tx_bits.push_back(tx_bytes[i][j]);
    repeat (extra) tx_bits.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic clock_bits(input int h, input int first, input int last);
    for (int i = first; i < last; i++) begin
      sdi = tx_bits[i];
      wait_neg(h);
      sck = 1'b1;
      last_rise = cyc;
      wait_neg(h);
      sck = 1'b0;
    end
  endtask

  task automatic run_frame(input int extra, input bit b2b_next);
    int h;
    build_bits(extra);
    h = $urandom_range(2, 4);
    cs_n = 1'b0;
    wait_neg($urandom_range(1, 4));
    clock_bits(h, 0, tx_bits.size());
    cs_n = 1'b1;
    raise_cyc = cyc;
    push_outcome();
    if (b2b_next) wait_neg(1);
    else          wait_neg($urandom_range(3, 8));
  endtask

  function automatic logic [7:0] good_sum();
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < PB-1; i++) x ^= tx_bytes[i];
    return x;
  endfunction

  // ---------------- main stimulus ----------------
  initial begin
    wait_neg(6);
    rst_n = 1'b1;
    wait_neg(8);

    // Good frame: latency and payload
    tx_bytes = '{8'hAA, 8'h12, 8'h34, 8'h03, 8'h8F};
    run_frame(0, 1'b0);
    wait_neg(4);
    chk("r37_latency", last_valid_cyc - raise_cyc, 4);
    chk("r37_ch", ch_data, 16'h1234);
    chk("r37_flags", flags, 8'h03);
    chk("r37_ok", ok_cnt, 16'd1);
    chk("r37_init", initialized, 1'b1);

    // Header wrong, checksum right
    tx_bytes = '{8'hAB, 8'h12, 8'h34, 8'h03, 8'h8E};
    run_frame(0, 1'b0);
    wait_neg(4);
    chk("r38_sticky", err_sticky, 4'b0001);
    chk("r38_err", err_cnt, 16'd1);
    chk("r38_ch", ch_data, 16'h1234);

    // Overlength frame, then a good one
    tx_bytes = '{8'hAA, 8'h12, 8'h34, 8'h03, 8'h8F, 8'h00};
    run_frame(0, 1'b0);
    wait_neg(4);
    chk("r39_len", err_sticky[1], 1'b1);
    tx_bytes = '{8'hAA, 8'h55, 8'h66, 8'h81, 8'h00};
    tx_bytes[4] = good_sum();
    run_frame(0, 1'b0);
    wait_neg(4);
    chk("r39_ok", ok_cnt, 16'd2);
    chk("r39_ch", ch_data, 16'h5566);

    // Timeout after two bytes; raising CS later yields nothing
    begin
      ev_t e;
      tx_bytes = '{8'hAA, 8'h12};
      build_bits(0);
      cs_n = 1'b0;
      wait_neg(2);
      clock_bits(3, 0, 16);
      e.cyc = last_rise + 3 + int'(TO); e.tmo = 1'b1; e.acc = 1'b0;
      e.bits = '0; e.ch = '0; e.fl = '0;
      ev_q.push_back(e);
      wait_neg(int'(TO) + 10);
      chk("r40_at", last_err_cyc - last_rise, 67);
      chk("r40_sticky", err_sticky[3], 1'b1);
      cs_n = 1'b1;
      wait_neg(12);
      chk("r40_err", err_cnt, 16'd3);
    end

    // CS falls again during the check cycle of the previous frame
    tx_bytes = '{8'hAA, 8'hBE, 8'hEF, 8'h5A, 8'h00};
    tx_bytes[4] = good_sum();
    run_frame(0, 1'b1);
    tx_bytes = '{8'hAA, 8'hC0, 8'hDE, 8'h11, 8'h00};
    tx_bytes[4] = good_sum();
    run_frame(0, 1'b0);
    wait_neg(4);
    chk("b2b_ch", ch_data, 16'hC0DE);

    // Randomized frames
    for (int n = 0; n < 30; n++) begin
      int kind, extra;
      kind = $urandom_range(0, 6);
      extra = 0;
      tx_bytes = '{8'hAA, 8'($urandom), 8'($urandom), 8'($urandom), 8'h00};
      tx_bytes[4] = good_sum();
      case (kind)
        1: begin
          tx_bytes[0] = 8'($urandom_range(0, 255));
          if (tx_bytes[0] == 8'hAA) tx_bytes[0] = 8'h2A;
          tx_bytes[4] = good_sum();
        end
        2: tx_bytes[4] = tx_bytes[4] ^ 8'($urandom_range(1, 255));
        3: repeat ($urandom_range(1, 4)) void'(tx_bytes.pop_back());
        4: repeat ($urandom_range(1, 2)) tx_bytes.push_back(8'($urandom));
        5: begin
          if ($urandom_range(0, 1) == 1) void'(tx_bytes.pop_back());
          extra = $urandom_range(1, 7);
        end
        6: tx_bytes.delete();
        default: ;
      endcase
      run_frame(extra, 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 5) == 0) begin
        err_clr = 1'b1;
        wait_neg(1);
        err_clr = 1'b0;
        wait_neg(2);
      end
    end
    wait_neg(10);

    // Reset in the middle of a frame, released with CS still low
    tx_bytes = '{8'hAA, 8'h12, 8'h34, 8'h03, 8'h8F};
    build_bits(0);
    cs_n = 1'b0;
    wait_neg(2);
    clock_bits(3, 0, 16);
    rst_n = 1'b0;
    wait_neg(3);
    rst_n = 1'b1;
    wait_neg(4);
    clock_bits(3, 16, 40);
    cs_n = 1'b1;
    wait_neg(12);
    chk("r41_ch", ch_data, 16'h0);
    chk("r41_flags", flags, 8'h0);
    chk("r41_ok", ok_cnt, 16'd0);
    chk("r41_err", err_cnt, 16'd0);
    chk("r41_init", initialized, 1'b0);
    tx_bytes = '{8'hAA, 8'h12, 8'h34, 8'h03, 8'h8F};
    run_frame(0, 1'b0);
    wait_neg(4);
    chk("r41_ch_after", ch_data, 16'h1234);
    chk("r41_ok_after", ok_cnt, 16'd1);

    // Saturation of err_cnt, then err_clr landing on a reject
    force dut.err_cnt = 16'hFFFF;
    m_err = 16'hFFFF;
    wait_neg(1);
    release dut.err_cnt;
    wait_neg(2);
    tx_bytes = '{8'hAB, 8'h12, 8'h34, 8'h03, 8'h8E};
    run_frame(0, 1'b0);
    wait_neg(4);
    chk("r42_sat", err_cnt, 16'hFFFF);
    tx_bytes = '{8'hAB, 8'h12, 8'h34, 8'h03, 8'h8E};
    build_bits(0);
    cs_n = 1'b0;
    wait_neg(2);
    clock_bits(2, 0, 40);
    cs_n = 1'b1;
    raise_cyc = cyc;
    push_outcome();
    wait_neg(3);
    err_clr = 1'b1;
    wait_neg(1);
    err_clr = 1'b0;
    chk("r42_clr_pulse", last_err_cyc - raise_cyc, 4);
    chk("r42_clr_cnt", err_cnt, 16'd0);
    chk("r42_clr_sticky", err_sticky, 4'd0);
    wait_neg(10);

    chk("events_drained", ev_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
